// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage.
// Holds the default widths, the opcode encoding, the FSM state encoding
// and a small opcode classification helper.
package exec_pkg;

    localparam int XLEN      = 32;
    localparam int AW        = 5;
    localparam int MUL_STEPS = XLEN;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // True for opcodes that complete in a single cycle (ADD..SLTU).
    function automatic logic op_is_single(input logic [3:0] op_v);
        return (op_v <= 4'd9);
    endfunction

endpackage

// File: rtl/exec_wb_unit_seq_multiplier.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   start         load operands and begin (ignored when not pulsed)
//   a, b          multiplicand / multiplier, sampled on start
//   done          high during the cycle whose edge completes the last step
//   product       accumulator; holds the final product after that edge
module seq_multiplier #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int SW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(MUL_STEPS - 1);

    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] acc_r;
    logic [SW-1:0]   step_r;
    logic            running_r;

    // Shift-add datapath and step counter; one partial product per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r   <= {XLEN{1'b0}};
            mplier_r  <= {XLEN{1'b0}};
            acc_r     <= {XLEN{1'b0}};
            step_r    <= {SW{1'b0}};
            running_r <= 1'b0;
        end else if (start) begin
            mcand_r   <= a;
            mplier_r  <= b;
            acc_r     <= {XLEN{1'b0}};
            step_r    <= {SW{1'b0}};
            running_r <= 1'b1;
        end else if (running_r) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (step_r == LAST_STEP) begin
                step_r    <= {SW{1'b0}};
                running_r <= 1'b0;
            end else begin
                step_r    <= step_r + SW'(1);
                running_r <= 1'b1;
            end
        end else begin
            running_r <= 1'b0;
        end
    end

    assign done    = running_r && (step_r == LAST_STEP);
    assign product = acc_r;

endmodule

// File: rtl/exec_wb_unit.sv
// Execute stage feeding the register-file write port.
// Single-cycle ALU ops write one cycle after accept; MUL runs an iterative
// multiplier and writes MUL_STEPS+1 cycles after accept.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   in_valid / in_ready     upstream handshake; accept when both high
//   op, rs1_data, rs2_data  opcode and operands, sampled at accept
//   rd                      destination index; x0 is never written
//   we, waddr, wbdata       registered write port, we is a one-cycle pulse
//   busy                    multiply in progress
module exec_wb_unit #(
    parameter int XLEN      = exec_pkg::XLEN,
    parameter int AW        = exec_pkg::AW,
    parameter int MUL_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd,
    output logic            we,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wbdata,
    output logic            busy
);

    import exec_pkg::*;

    localparam int SHW = $clog2(XLEN);

    state_e            state_r;
    logic              we_r;
    logic [AW-1:0]     waddr_r;
    logic [XLEN-1:0]   wbdata_r;
    logic              busy_r;
    logic [AW-1:0]     mul_rd_r;

    op_e               op_s;
    logic              accept_s;
    logic              mul_start_s;
    logic              mul_done_s;
    logic [XLEN-1:0]   mul_product_s;
    logic [XLEN-1:0]   alu_res_s;
    logic [SHW-1:0]    shamt_s;

    assign op_s        = op_e'(op);
    assign in_ready    = (state_r == ST_IDLE);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (op_s == OP_MUL);
    assign shamt_s     = rs2_data[SHW-1:0];

    seq_multiplier #(
        .XLEN      (XLEN),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (rs1_data),
        .b       (rs2_data),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ALU result for the op currently presented.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (op_s)
            OP_ADD:  alu_res_s = rs1_data + rs2_data;
            OP_SUB:  alu_res_s = rs1_data - rs2_data;
            OP_AND:  alu_res_s = rs1_data & rs2_data;
            OP_OR:   alu_res_s = rs1_data | rs2_data;
            OP_XOR:  alu_res_s = rs1_data ^ rs2_data;
            OP_SLL:  alu_res_s = rs1_data << shamt_s;
            OP_SRL:  alu_res_s = rs1_data >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(rs1_data) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (rs1_data < rs2_data)};
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and registered write port; waddr/wbdata change only on writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            we_r     <= 1'b0;
            waddr_r  <= {AW{1'b0}};
            wbdata_r <= {XLEN{1'b0}};
            busy_r   <= 1'b0;
            mul_rd_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    we_r <= 1'b0;
                    if (mul_start_s) begin
                        state_r  <= ST_MUL;
                        busy_r   <= 1'b1;
                        mul_rd_r <= rd;
                    end else if (accept_s && op_is_single(op) && (rd != {AW{1'b0}})) begin
                        we_r     <= 1'b1;
                        waddr_r  <= rd;
                        wbdata_r <= alu_res_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    we_r <= 1'b0;
                    if (mul_done_s) begin
                        state_r <= ST_WB;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_WB: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (mul_rd_r != {AW{1'b0}}) begin
                        we_r     <= 1'b1;
                        waddr_r  <= mul_rd_r;
                        wbdata_r <= mul_product_s;
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign we     = we_r;
    assign waddr  = waddr_r;
    assign wbdata = wbdata_r;
    assign busy   = busy_r;

endmodule

// File: doc/exec_wb_unit.md
Name: exec_wb_unit

Overview:
- Execute stage directly downstream of the 2-read/1-write register file.
- Consumes rs1_data/rs2_data with a decoded opcode and destination index.
- Computes single-cycle ALU ops, or a 32-step iterative multiply.
- Drives the register-file write port (we, waddr, wbdata) with a one-cycle write pulse per accepted op.

Parameters:
- XLEN, 32, operand/result width.
- AW, 5, register index width.
- MUL_STEPS, XLEN, shift-add iterations per multiply.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream presents an op this cycle.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  opcode (see package).
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- rd  in  AW  destination register index.
- we  out  1  write-enable to register file, one-cycle pulse.
- waddr  out  AW  write address, valid when we=1.
- wbdata  out  XLEN  write data, valid when we=1.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, step counter=0.
  - we=0, waddr=0, wbdata=0, busy=0.
  - in_ready=1 is asserted combinationally once state=IDLE.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE).
  - op, rs1_data, rs2_data and rd are sampled only at accept.
- FSM states: IDLE, MUL, WB.
- IDLE, accepting a single-cycle op:
  - ADD=0: a+b.
  - SUB=1: a-b.
  - AND=2, OR=3, XOR=4.
  - SLL=5: a<<b[4:0].
  - SRL=6: logical a>>b[4:0].
  - SRA=7: arithmetic a>>>b[4:0].
  - SLT=8: signed a<b, result 1/0 zero-extended.
  - SLTU=9: unsigned a<b, result 1/0 zero-extended.
  - Result is registered; we=1 in the cycle after accept (latency 1). State stays IDLE, so back-to-back accepts give one write per cycle.
- IDLE, accepting MUL=10:
  - Latch multiplicand, multiplier and rd; clear accumulator; step=0; go to MUL; busy=1.
- MUL:
  - Each edge: if multiplier[0], accumulator += multiplicand; then multiplicand<<=1, multiplier>>=1, step++.
  - When step reaches MUL_STEPS-1 and that step completes, go to WB.
- WB:
  - One cycle with we=1, wbdata = low XLEN bits of the product, waddr = latched rd. Then go to IDLE with busy=0.
  - Accept-to-we latency is MUL_STEPS+1 cycles (33 at default).
- Arithmetic: all add/sub wrap modulo 2^XLEN; no overflow flag. The multiply result is the low XLEN bits, identical for signed and unsigned operands.
- rd==0: the op executes and timing is unchanged, but we is forced to 0 (x0 is never written).
- Illegal op (11..15): accepted, no write, no state change beyond the accept.
- we is 0 in every cycle not listed above; waddr/wbdata hold their last value when we=0.
- in_valid while busy: ignored (in_ready=0); upstream must hold the op.
- Reset mid-multiply: aborts immediately, no write is produced, and the block is back in IDLE with in_ready=1.
- The downstream register file registers its write inputs; its extra cycle is outside this block and needs no compensation here.

Decomposition:
- Package exec_pkg:
  - XLEN and AW constants.
  - op_e enum (ADD..MUL, values 0..10).
  - state_e enum (IDLE, MUL, WB).
  - MUL_STEPS default.
- Sub-module seq_multiplier:
  - Holds the shift-add datapath and step counter.
  - Interface: start, a, b, done pulse, product.
  - The top block holds the FSM, ALU and write-port registers.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> we=0, busy=0 and in_ready=1 immediately.
- Single-cycle ALU op: accept ADD a=0x7FFFFFFF, b=1, rd=3 -> next cycle we=1, waddr=3, wbdata=0x80000000.
- SUB/compare set: SUB 0,1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; SRA 0x80000000,4 -> 0xF8000000.
- Multiply: accept MUL 0x00012345, 0x00000100, rd=7 -> in_ready=0 for 33 cycles, then a single we=1 with waddr=7, wbdata=0x01234500; a second MUL 0xFFFFFFFF x 0xFFFFFFFF -> wbdata=0x00000001.
- Back-to-back with rd=0: ADD rd=5, ADD rd=0, XOR rd=6 on consecutive cycles -> we pattern 1,0,1 with waddr 5,-,6; in_valid held during MUL is not accepted until in_ready=1.
- Reset during MUL at step 10 -> no we pulse ever; the next ADD accepted after reset writes correctly one cycle later.
